uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 147 ++++++++++++++
 tb/tb_uart_rx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: the 3-bit state encoding common to the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; flops reset to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled by CLK_PER_BIT, start-bit glitch reject, optional parity,
// 1..2 stop bits, and a BREAK hold while the line stays low after a bad stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BIT_COUNT   = 8,
  parameter int PARITY_BIT_COUNT = 0,
  parameter int PARITY_ODD       = 0,
  parameter int STOP_BIT_COUNT   = 1,
  parameter int CLK_PER_BIT      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      serial,
  output logic [DATA_BIT_COUNT-1:0] data,
  output logic                      data_valid,
  output logic                      parity_error,
  output logic                      framing_error,
  output logic                      busy
);

  localparam int             CW        = $clog2(CLK_PER_BIT) + 1;
  localparam int             IW        = 4;
  localparam logic [CW-1:0]  HALF_M1   = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_M1    = CW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0]  LAST_DATA = IW'(DATA_BIT_COUNT - 1);
  localparam logic [IW-1:0]  LAST_STOP = IW'(STOP_BIT_COUNT - 1);
  localparam logic           ODD       = 1'(PARITY_ODD);

  uart_state_t               state, state_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic [IW-1:0]             idx, idx_n;
  logic [DATA_BIT_COUNT-1:0] data_r, data_r_n, data_n;
  logic                      par_err_r, par_n, frm_err_r, frm_n;
  logic                      dv_n, pe_n, fe_n;
  logic                      line_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial),
    .q   (line_s)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    idx_n    = idx;
    data_r_n = data_r;
    par_n    = par_err_r;
    frm_n    = frm_err_r;
    data_n   = data;
    dv_n     = 1'b0;
    pe_n     = 1'b0;
    fe_n     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!line_s) begin
          state_n = START;
          par_n   = 1'b0;
          frm_n   = 1'b0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          state_n = line_s ? IDLE : DATA;
        end
      end
      DATA: begin
        // shifting in at the MSB leaves the first (LSB) bit at data_r[0] once the word is full
        if (cnt == BIT_M1) begin
          cnt_n    = '0;
          data_r_n = {line_s, data_r[DATA_BIT_COUNT-1:1]};
          if (idx == LAST_DATA) begin
            idx_n   = '0;
            state_n = (PARITY_BIT_COUNT > 0) ? PARITY : STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (cnt == BIT_M1) begin
          cnt_n   = '0;
          par_n   = line_s ^ (^data_r) ^ ODD;
          state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_M1) begin
          cnt_n = '0;
          frm_n = frm_err_r | ~line_s;
          if (idx == LAST_STOP) begin
            idx_n   = '0;
            dv_n    = 1'b1;
            data_n  = data_r;
            pe_n    = par_err_r;
            fe_n    = frm_err_r | ~line_s;
            state_n = line_s ? IDLE : BREAK;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (line_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      data_r        <= '0;
      par_err_r     <= 1'b0;
      frm_err_r     <= 1'b0;
      data          <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      idx           <= idx_n;
      data_r        <= data_r_n;
      par_err_r     <= par_n;
      frm_err_r     <= frm_n;
      data          <= data_n;
      data_valid    <= dv_n;
      parity_error  <= pe_n;
      framing_error <= fe_n;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1, 8E1 and 8N2 instances share clk/rst, each with its own line.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_a = 1'b1, ser_b = 1'b1, ser_c = 1'b1;
  logic [7:0] data_a, data_b, data_c;
  logic dv_a, dv_b, dv_c, pe_a, pe_b, pe_c, fe_a, fe_b, fe_c, busy_a, busy_b, busy_c;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // per-instance monitor records: pulse count, cycle of last pulse, previous pulse, captured outputs
  int a_cnt = 0, b_cnt = 0, c_cnt = 0;
  int a_cyc = 0, c_cyc = 0, c_prev = 0;
  logic [7:0] a_d, b_d, c_d;
  logic a_pe, a_fe, b_pe, b_fe;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.DATA_BIT_COUNT(8), .PARITY_BIT_COUNT(0), .PARITY_ODD(0),
            .STOP_BIT_COUNT(1), .CLK_PER_BIT(CPB)) u_a (
    .clk(clk), .rst(rst), .serial(ser_a), .data(data_a), .data_valid(dv_a),
    .parity_error(pe_a), .framing_error(fe_a), .busy(busy_a));

  uart_rx #(.DATA_BIT_COUNT(8), .PARITY_BIT_COUNT(1), .PARITY_ODD(0),
            .STOP_BIT_COUNT(1), .CLK_PER_BIT(CPB)) u_b (
    .clk(clk), .rst(rst), .serial(ser_b), .data(data_b), .data_valid(dv_b),
    .parity_error(pe_b), .framing_error(fe_b), .busy(busy_b));

  uart_rx #(.DATA_BIT_COUNT(8), .PARITY_BIT_COUNT(0), .PARITY_ODD(0),
            .STOP_BIT_COUNT(2), .CLK_PER_BIT(CPB)) u_c (
    .clk(clk), .rst(rst), .serial(ser_c), .data(data_c), .data_valid(dv_c),
    .parity_error(pe_c), .framing_error(fe_c), .busy(busy_c));

  always @(negedge clk) begin
    if (dv_a) begin a_cnt <= a_cnt + 1; a_cyc <= cyc; a_d <= data_a; a_pe <= pe_a; a_fe <= fe_a; end
    if (dv_b) begin b_cnt <= b_cnt + 1; b_d <= data_b; b_pe <= pe_b; b_fe <= fe_b; end
    if (dv_c) begin c_cnt <= c_cnt + 1; c_prev <= c_cyc; c_cyc <= cyc; c_d <= data_c; end
  end

  task automatic set_line(input int inst, input logic v);
    case (inst)
      0: ser_a = v;
      1: ser_b = v;
      default: ser_c = v;
    endcase
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // called #1 after a posedge; t_edge is the first edge that sees the falling start edge
  task automatic send_frame(input int inst, input logic [7:0] d, input int npar, input logic pbit,
                            input int nstop, input logic sv, output int t_edge);
    logic [11:0] bits;
    int n;
    bits = '0;
    n = 1;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
    if (npar != 0) begin bits[n] = pbit; n++; end
    for (int i = 0; i < nstop; i++) begin bits[n] = sv; n++; end
    t_edge = cyc + 1;
    for (int i = 0; i < n; i++) begin
      set_line(inst, bits[i]);
      idle_cycles(CPB);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    total++; if (dv_a !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", dv_a); end
    total++; if (data_a !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_a); end
    total++; if ({pe_a, fe_a} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {pe_a, fe_a}); end
    total++; if (u_a.state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", u_a.state, IDLE); end
    rst = 1'b0;
    idle_cycles(4);
  endtask

  task automatic test_basic();
    int t, n0;
    n0 = a_cnt;
    send_frame(0, 8'hA5, 0, 1'b0, 1, 1'b1, t);
    ser_a = 1'b1;
    idle_cycles(8);
    total++; if (a_cnt !== n0 + 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=%0d", a_cnt - n0, 1); end
    total++; if (a_d !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", a_d); end
    total++; if (a_cyc !== t + 78) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", a_cyc - t, 78); end
    total++; if ({a_pe, a_fe} !== 2'b00) begin bad++; $display("FAIL basic_err got=%b exp=00", {a_pe, a_fe}); end
    total++; if (data_a !== 8'hA5) begin bad++; $display("FAIL basic_hold got=%h exp=a5", data_a); end
  endtask

  task automatic test_glitch();
    int n0;
    logic seen;
    n0 = a_cnt;
    seen = 1'b0;
    ser_a = 1'b0;
    idle_cycles(3);
    ser_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy_a) seen = 1'b1;
      if (!busy_a && seen) break;
    end
    total++; if (!(seen && busy_a === 1'b0)) begin bad++; $display("FAIL glitch_busy got=%b seen=%b exp=0", busy_a, seen); end
    idle_cycles(20);
    total++; if (a_cnt !== n0) begin bad++; $display("FAIL glitch_no_dv got=%0d exp=0", a_cnt - n0); end
  endtask

  task automatic test_parity();
    int t, n0;
    n0 = b_cnt;
    send_frame(1, 8'h03, 1, 1'b1, 1, 1'b1, t);
    idle_cycles(8);
    total++; if (b_cnt !== n0 + 1) begin bad++; $display("FAIL par_pulses got=%0d exp=1", b_cnt - n0); end
    total++; if (b_d !== 8'h03) begin bad++; $display("FAIL par_data got=%h exp=03", b_d); end
    total++; if ({b_pe, b_fe} !== 2'b10) begin bad++; $display("FAIL par_err got=%b exp=10", {b_pe, b_fe}); end
    send_frame(1, 8'h07, 1, 1'b1, 1, 1'b1, t);
    idle_cycles(8);
    total++; if (b_d !== 8'h07 || b_cnt !== n0 + 2) begin bad++; $display("FAIL par_ok_data got=%h exp=07", b_d); end
    total++; if ({b_pe, b_fe} !== 2'b00) begin bad++; $display("FAIL par_ok_err got=%b exp=00", {b_pe, b_fe}); end
  endtask

  task automatic test_framing();
    int t, n0;
    n0 = a_cnt;
    send_frame(0, 8'h55, 0, 1'b0, 1, 1'b0, t);
    idle_cycles(40);
    total++; if (a_cnt !== n0 + 1) begin bad++; $display("FAIL frm_pulses got=%0d exp=1", a_cnt - n0); end
    total++; if (a_d !== 8'h55) begin bad++; $display("FAIL frm_data got=%h exp=55", a_d); end
    total++; if ({a_pe, a_fe} !== 2'b01) begin bad++; $display("FAIL frm_err got=%b exp=01", {a_pe, a_fe}); end
    total++; if (u_a.state !== BREAK || busy_a !== 1'b1) begin bad++; $display("FAIL frm_break got=%0d/%b exp=%0d/1", u_a.state, busy_a, BREAK); end
    ser_a = 1'b1;
    idle_cycles(5);
    total++; if (busy_a !== 1'b0 || a_cnt !== n0 + 1) begin bad++; $display("FAIL frm_release got=%b/%0d exp=0/1", busy_a, a_cnt - n0); end
  endtask

  task automatic test_back_to_back();
    int t0, t1, n0;
    n0 = c_cnt;
    send_frame(2, 8'h00, 0, 1'b0, 2, 1'b1, t0);
    send_frame(2, 8'hFF, 0, 1'b0, 2, 1'b1, t1);
    idle_cycles(10);
    total++; if (c_cnt !== n0 + 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", c_cnt - n0); end
    total++; if (c_cyc - c_prev !== 88) begin bad++; $display("FAIL b2b_gap got=%0d exp=88", c_cyc - c_prev); end
    total++; if (c_cyc !== t0 + 88 + 2 + 4 + 80) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", c_cyc - t0, 174); end
    total++; if (c_d !== 8'hFF) begin bad++; $display("FAIL b2b_data got=%h exp=ff", c_d); end
  endtask

  task automatic test_reset_abort();
    int t, n0;
    logic [7:0] w;
    w = 8'h3C;
    n0 = a_cnt;
    ser_a = 1'b0;
    idle_cycles(CPB);
    for (int i = 0; i < 4; i++) begin ser_a = w[i]; idle_cycles(CPB); end
    ser_a = w[4];
    idle_cycles(4);
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    ser_a = 1'b1;
    total++; if (busy_a !== 1'b0 || data_a !== 8'h00) begin bad++; $display("FAIL abort_state got=%b/%h exp=0/00", busy_a, data_a); end
    idle_cycles(60);
    total++; if (a_cnt !== n0) begin bad++; $display("FAIL abort_no_dv got=%0d exp=0", a_cnt - n0); end
    send_frame(0, 8'h81, 0, 1'b0, 1, 1'b1, t);
    idle_cycles(8);
    total++; if (a_cnt !== n0 + 1 || a_d !== 8'h81) begin bad++; $display("FAIL abort_resume got=%0d/%h exp=1/81", a_cnt - n0, a_d); end
    total++; if (a_cyc !== t + 78 || {a_pe, a_fe} !== 2'b00) begin bad++; $display("FAIL abort_timing got=%0d err=%b exp=78", a_cyc - t, {a_pe, a_fe}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_framing();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
